// File: rtl/rx_pkg.sv
// Shared state encoding, oversample constants and helpers for the UART RX controller.
package rx_pkg;

   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_PRESC_W = 6;

   localparam int unsigned PRESC_8  = 8;
   localparam int unsigned PRESC_16 = 16;
   localparam int unsigned PRESC_32 = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   // Map a requested oversample ratio onto a supported one; anything unsupported runs at x8.
   function automatic int unsigned presc_sel(input int unsigned req);
      if (req == PRESC_16 || req == PRESC_32) begin
         return req;
      end
      return PRESC_8;
   endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter with the bit-end flag.
module rx_edge_bit_counter #(
   parameter int unsigned PRESC_W = 6,
   parameter int unsigned BIT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cnt_en,
   input  logic               cnt_start,
   input  logic               bit_run,
   input  logic [PRESC_W-1:0] presc,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]   bit_cnt,
   output logic               bit_end_c
);

   assign bit_end_c = cnt_en && (edge_cnt == (presc - PRESC_W'(1)));

   // Edge counter: the start-detect cycle is edge 0, so counting resumes at 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
      end else if (cnt_en) begin
         edge_cnt <= bit_end_c ? '0 : edge_cnt + PRESC_W'(1);
      end else begin
         edge_cnt <= cnt_start ? PRESC_W'(1) : '0;
      end
   end

   // Data-bit index: held at zero outside the data phase, advances at each bit end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
      end else if (!bit_run) begin
         bit_cnt <= '0;
      end else if (bit_end_c) begin
         bit_cnt <= bit_cnt + BIT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, 3-sample majority vote, deserializer strobes, parity/stop checks.
module uart_rx_ctrl
   import rx_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_in,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               par_en,
   input  logic               par_typ,
   input  logic [DATA_W-1:0]  deser_data,
   output logic               sampled_bit,
   output logic               deser_en,
   output logic               data_valid,
   output logic               par_err,
   output logic               stp_err,
   output logic               busy
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   rx_state_e          state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               par_en_q, par_en_d;
   logic               par_typ_q, par_typ_d;
   logic               frm_err_q, frm_err_d;
   logic               deser_en_d, data_valid_d, par_err_d, stp_err_d, busy_d;
   logic               vote0_q, vote1_q;
   logic [PRESC_W-1:0] edge_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic               bit_end_c;
   logic [PRESC_W-1:0] mid, mid_m1, mid_p1;
   logic               cnt_en, cnt_start, bit_run, exp_par;

   assign mid       = presc_q >> 1;
   assign mid_m1    = mid - PRESC_W'(1);
   assign mid_p1    = mid + PRESC_W'(1);
   assign cnt_en    = (state_q != IDLE);
   assign cnt_start = (state_q == IDLE) && !rx_in;
   assign bit_run   = (state_q == DATA);
   assign exp_par   = (^deser_data) ^ par_typ_q;

   rx_edge_bit_counter #(
      .PRESC_W (PRESC_W),
      .BIT_W   (BIT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .cnt_en    (cnt_en),
      .cnt_start (cnt_start),
      .bit_run   (bit_run),
      .presc     (presc_q),
      .edge_cnt  (edge_cnt),
      .bit_cnt   (bit_cnt),
      .bit_end_c (bit_end_c)
   );

   // Majority sampler: capture mid-1 and mid, vote with mid+1 so the result lands at mid+2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vote0_q     <= 1'b0;
         vote1_q     <= 1'b0;
         sampled_bit <= 1'b0;
      end else if (cnt_en) begin
         if (edge_cnt == mid_m1) vote0_q <= rx_in;
         if (edge_cnt == mid)    vote1_q <= rx_in;
         if (edge_cnt == mid_p1) begin
            sampled_bit <= (vote0_q & vote1_q) | (vote0_q & rx_in) | (vote1_q & rx_in);
         end
      end
   end

   // State, latched frame configuration and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         presc_q    <= PRESC_W'(PRESC_8);
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         deser_en   <= 1'b0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         frm_err_q  <= frm_err_d;
         deser_en   <= deser_en_d;
         data_valid <= data_valid_d;
         par_err    <= par_err_d;
         stp_err    <= stp_err_d;
         busy       <= busy_d;
      end
   end

   // Next-state and output decode; frame configuration is captured only when a frame starts.
   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      frm_err_d    = frm_err_q;
      deser_en_d   = 1'b0;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_in) begin
               state_d   = START;
               presc_d   = PRESC_W'(presc_sel(32'(prescale)));
               par_en_d  = par_en;
               par_typ_d = par_typ;
            end
         end
         START: begin
            if (bit_end_c) begin
               state_d = sampled_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            // Registered one cycle early so the strobe is high while edge_cnt == mid+2.
            deser_en_d = (edge_cnt == mid_p1);
            if (bit_end_c && (bit_cnt == BIT_W'(DATA_W - 1))) begin
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end_c) begin
               if (sampled_bit != exp_par) begin
                  frm_err_d = 1'b1;
                  par_err_d = 1'b1;
               end
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end_c) begin
               if (!sampled_bit) begin
                  stp_err_d = 1'b1;
               end else if (!frm_err_q) begin
                  data_valid_d = 1'b1;
               end
               frm_err_d = 1'b0;
               if (!rx_in) begin
                  state_d   = START;
                  presc_d   = PRESC_W'(presc_sel(32'(prescale)));
                  par_en_d  = par_en;
                  par_typ_d = par_typ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised self-checking bench for uart_rx_ctrl against a frame-level timing model.
module tb_uart_rx_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_in;
   logic [PW-1:0] prescale;
   logic          par_en;
   logic          par_typ;
   logic [DW-1:0] deser_q;
   logic          sampled_bit, deser_en, data_valid, par_err, stp_err, busy;

   int cyc      = 0;
   int n_vec    = 0;
   int n_bad    = 0;
   int excl_bad = 0;

   int de_act[$], dv_act[$], pe_act[$], se_act[$], by_act[$];
   int de_exp[$], dv_exp[$], pe_exp[$], se_exp[$], by_exp[$];

   uart_rx_ctrl #(.DATA_W(DW), .PRESC_W(PW)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .prescale    (prescale),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .deser_data  (deser_q),
      .sampled_bit (sampled_bit),
      .deser_en    (deser_en),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Environment deserializer: LSB-first shift on each capture strobe, shares rst.
   always @(posedge clk or negedge rst) begin
      if (!rst)          deser_q <= '0;
      else if (deser_en) deser_q <= {sampled_bit, deser_q[DW-1:1]};
   end

   // Output monitor: timestamp every pulse, mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (deser_en) de_act.push_back(cyc);
         if (data_valid) begin
            dv_act.push_back(cyc);
            by_act.push_back(int'(deser_q));
         end
         if (par_err) pe_act.push_back(cyc);
         if (stp_err) se_act.push_back(cyc);
         if (int'(data_valid) + int'(par_err) + int'(stp_err) > 1) excl_bad++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic cmp_q(input string tag, input int act[$], input int exp[$]);
      chk({tag, "_count"}, act.size(), exp.size());
      for (int i = 0; i < act.size() && i < exp.size(); i++) begin
         chk($sformatf("%s[%0d]", tag, i), act[i], exp[i]);
      end
   endtask

   task automatic flush(input string tag);
      repeat (4) @(negedge clk);
      cmp_q({tag, "/deser_en"}, de_act, de_exp);
      cmp_q({tag, "/data_valid"}, dv_act, dv_exp);
      cmp_q({tag, "/byte"}, by_act, by_exp);
      cmp_q({tag, "/par_err"}, pe_act, pe_exp);
      cmp_q({tag, "/stp_err"}, se_act, se_exp);
      chk({tag, "/exclusive"}, excl_bad, 0);
      de_act.delete(); dv_act.delete(); pe_act.delete(); se_act.delete(); by_act.delete();
      de_exp.delete(); dv_exp.delete(); pe_exp.delete(); se_exp.delete(); by_exp.delete();
      excl_bad = 0;
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "/sampled_bit"}, int'(sampled_bit), 0);
      chk({tag, "/deser_en"},    int'(deser_en), 0);
      chk({tag, "/data_valid"},  int'(data_valid), 0);
      chk({tag, "/par_err"},     int'(par_err), 0);
      chk({tag, "/stp_err"},     int'(stp_err), 0);
      chk({tag, "/busy"},        int'(busy), 0);
   endtask

   function automatic int p_eff(input logic [PW-1:0] pin);
      if (pin == PW'(16) || pin == PW'(32)) return int'(pin);
      return 8;
   endfunction

   // Drive one frame bit-by-bit and record what the receiver must produce for it.
   task automatic send_frame(input logic [7:0] d, input logic [PW-1:0] pin, input logic pen,
                             input logic ptyp, input logic par_bad, input logic stop_v,
                             input int noise_bit, input logic [PW-1:0] chg_p, input int rst_bit);
      int p, nb, t0, tend;
      logic [10:0] bits;
      p  = p_eff(pin);
      nb = pen ? 11 : 10;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      if (pen) bits[9] = (^d) ^ ptyp ^ par_bad;
      bits[nb-1] = stop_v;
      t0   = cyc + 1;
      tend = t0 + nb * p - 1;
      if (rst_bit < 0) begin
         for (int k = 1; k <= 8; k++) de_exp.push_back(t0 + k * p + p / 2 + 1);
         if (pen && par_bad) pe_exp.push_back(t0 + 10 * p - 1);
         if (!stop_v) begin
            se_exp.push_back(tend);
         end else if (!(pen && par_bad)) begin
            dv_exp.push_back(tend);
            by_exp.push_back(int'(d));
         end
      end else begin
         for (int k = 1; k < rst_bit; k++) de_exp.push_back(t0 + k * p + p / 2 + 1);
      end
      prescale = pin;
      par_en   = pen;
      par_typ  = ptyp;
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < p; c++) begin
            if (b == rst_bit && c == p / 2) begin
               rst = 1'b0;
               #1;
               chk_outs_zero("rst_mid_frame");
               repeat (3) @(negedge clk);
               rx_in = 1'b1;
               rst   = 1'b1;
               repeat (2) @(negedge clk);
               return;
            end
            rx_in = bits[b] ^ (b == noise_bit && c == p / 2);
            if (chg_p != '0 && b == 3 && c == 1) begin
               prescale = chg_p;
               par_en   = ~pen;
               par_typ  = ~ptyp;
            end
            @(negedge clk);
         end
      end
      rx_in = 1'b1;
      if (!stop_v) repeat (40) @(negedge clk);
   endtask

   initial begin
      logic [PW-1:0] pl, pc;
      rst = 1'b0; rx_in = 1'b1; prescale = PW'(8); par_en = 1'b0; par_typ = 1'b0;
      repeat (3) @(negedge clk);
      chk_outs_zero("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      send_frame(8'hA5, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, '0, -1);
      flush("p8_a5");

      send_frame(8'h07, PW'(16), 1'b1, 1'b0, 1'b0, 1'b1, -1, '0, -1);
      send_frame(8'h07, PW'(16), 1'b1, 1'b0, 1'b1, 1'b1, -1, '0, -1);
      flush("p16_parity");

      prescale = PW'(8); par_en = 1'b0;
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
      rx_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("glitch_busy_hold", int'(busy), 1);
      @(negedge clk);
      chk("glitch_busy_drop", int'(busy), 0);
      flush("glitch");

      send_frame(8'h96, PW'(32), 1'b0, 1'b0, 1'b0, 1'b0, -1, '0, -1);
      send_frame(8'h69, PW'(32), 1'b0, 1'b0, 1'b0, 1'b1, 3, '0, -1);
      flush("p32_stop_noise");

      send_frame(8'h3C, PW'(16), 1'b0, 1'b0, 1'b0, 1'b1, -1, '0, -1);
      send_frame(8'hC3, PW'(16), 1'b0, 1'b0, 1'b0, 1'b1, -1, '0, -1);
      flush("back_to_back");

      send_frame(8'hFF, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, '0, 5);
      send_frame(8'h5A, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, PW'(16), -1);
      flush("reset_then_5a");

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 4))
            0: pl = PW'(8);
            1: pl = PW'(16);
            2: pl = PW'(32);
            3: pl = PW'(12);
            default: pl = PW'($urandom_range(33, 63));
         endcase
         case ($urandom_range(0, 5))
            0: pc = PW'(8);
            1: pc = PW'(16);
            2: pc = PW'(32);
            default: pc = '0;
         endcase
         send_frame(8'($urandom), pl, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1, pc, -1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (n % 10 == 9) flush($sformatf("random_%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
